// File: rtl/bcd_display_scanner.sv
// Five-digit multiplexed 7-segment scanner with per-frame digit snapshot,
// leading-zero blanking and whole-display blink. Segments and anodes are active-low.
module bcd_display_scanner #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] D5,
   input  logic [3:0] D4,
   input  logic [3:0] D3,
   input  logic [3:0] D2,
   input  logic [3:0] D1,
   input  logic       blank_lz,
   input  logic       blink_en,
   output logic [4:0] an,
   output logic [6:0] seg
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [0:0]    PH_VISIBLE = 1'b0;
   localparam logic [0:0]    PH_HIDDEN  = 1'b1;
   localparam logic [2:0]    IDX_LAST   = 3'd4;
   localparam logic [3:0]    CODE_BLANK = 4'd15;
   localparam logic [6:0]    SEG_BLANK  = 7'b1111111;
   localparam logic [4:0]    AN_OFF     = 5'b11111;

   logic [SW-1:0]   slot_cnt_r;
   logic [2:0]      idx_r;
   logic [FW-1:0]   frame_cnt_r;
   logic [0:0]      phase_r;
   logic [4:0][3:0] shadow_r;
   logic [4:0]      an_r;
   logic [6:0]      seg_r;

   logic            slot_tc_s;
   logic            frame_wrap_s;
   logic [4:0]      lz_s;
   logic [3:0]      digit_s;
   logic            blank_s;
   logic [4:0]      an_sel_s;
   logic [4:0]      an_next_s;
   logic [6:0]      seg_next_s;

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         4'd15:   s = SEG_BLANK;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   assign slot_tc_s    = (slot_cnt_r == SLOT_LAST);
   assign frame_wrap_s = slot_tc_s && (idx_r == IDX_LAST);

   // Slot timer and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt_r <= {SW{1'b0}};
         idx_r      <= 3'd0;
      end else if (slot_tc_s) begin
         slot_cnt_r <= {SW{1'b0}};
         idx_r      <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
      end else begin
         slot_cnt_r <= slot_cnt_r + SW'(1);
      end
   end

   // Snapshot all digits at the frame wrap so a frame never mixes two codes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_r <= {5{CODE_BLANK}};
      end else if (frame_wrap_s) begin
         shadow_r <= {D5, D4, D3, D2, D1};
      end else begin
         shadow_r <= shadow_r;
      end
   end

   // Blink frame counter; held at visible while blink is disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_r <= {FW{1'b0}};
         phase_r     <= PH_VISIBLE;
      end else if (!blink_en) begin
         frame_cnt_r <= {FW{1'b0}};
         phase_r     <= PH_VISIBLE;
      end else if (frame_wrap_s) begin
         if (frame_cnt_r == FRAME_LAST) begin
            frame_cnt_r <= {FW{1'b0}};
            phase_r     <= ~phase_r;
         end else begin
            frame_cnt_r <= frame_cnt_r + FW'(1);
         end
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   // Leading-zero chain: a zero blanks only while everything above it is 0 or blank
   always_comb begin : lz_chain
      logic hz;
      hz   = 1'b1;
      lz_s = 5'b00000;
      for (int k = 4; k >= 1; k--) begin
         lz_s[k] = blank_lz && hz && (shadow_r[k] == 4'd0);
         hz      = hz && ((shadow_r[k] == 4'd0) || (shadow_r[k] == CODE_BLANK));
      end
   end

   // Select current digit and its anode
   always_comb begin
      digit_s  = CODE_BLANK;
      blank_s  = 1'b1;
      an_sel_s = AN_OFF;
      case (idx_r)
         3'd0: begin digit_s = shadow_r[0]; blank_s = lz_s[0]; an_sel_s = 5'b11110; end
         3'd1: begin digit_s = shadow_r[1]; blank_s = lz_s[1]; an_sel_s = 5'b11101; end
         3'd2: begin digit_s = shadow_r[2]; blank_s = lz_s[2]; an_sel_s = 5'b11011; end
         3'd3: begin digit_s = shadow_r[3]; blank_s = lz_s[3]; an_sel_s = 5'b10111; end
         3'd4: begin digit_s = shadow_r[4]; blank_s = lz_s[4]; an_sel_s = 5'b01111; end
         default: begin digit_s = CODE_BLANK; blank_s = 1'b1; an_sel_s = AN_OFF; end
      endcase
   end

   // Next output value including blink and blanking
   always_comb begin
      an_next_s  = AN_OFF;
      seg_next_s = SEG_BLANK;
      if (blink_en && (phase_r == PH_HIDDEN)) begin
         an_next_s  = AN_OFF;
         seg_next_s = SEG_BLANK;
      end else if (blank_s) begin
         an_next_s  = an_sel_s;
         seg_next_s = SEG_BLANK;
      end else begin
         an_next_s  = an_sel_s;
         seg_next_s = seg_decode(digit_s);
      end
   end

   // Registered display outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r  <= AN_OFF;
         seg_r <= SEG_BLANK;
      end else begin
         an_r  <= an_next_s;
         seg_r <= seg_next_s;
      end
   end

   assign an  = an_r;
   assign seg = seg_r;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2 (20-clock frames).
module tb_bcd_display_scanner;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;
   localparam logic [4:0] AN_OFF = 5'b11111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] D5, D4, D3, D2, D1;
   logic       blank_lz = 1'b0;
   logic       blink_en = 1'b0;
   logic [4:0] an;
   logic [6:0] seg;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_display_scanner #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst),
      .D5(D5), .D4(D4), .D3(D3), .D2(D2), .D1(D1),
      .blank_lz(blank_lz), .blink_en(blink_en),
      .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: an/seg got=%b_%b exp=%b_%b", tag, $time,
                  got[11:7], got[6:0], exp[11:7], exp[6:0]);
      end
   endtask

   task automatic set_d(input logic [19:0] v);
      {D5, D4, D3, D2, D1} = v;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Checks one full frame starting right after a wrap edge; slot i shows sN[i].
   task automatic run_frame(input string tag,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [6:0] s4,
                            input logic hid, input int chg_at, input logic [19:0] chg_val);
      logic [6:0] sv [5];
      logic [4:0] one;
      logic [4:0] ea;
      logic [6:0] es;
      sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3; sv[4] = s4;
      one = 5'b00001;
      for (int i = 0; i < 5; i++) begin
         for (int c = 0; c < 4; c++) begin
            tick(1);
            ea = hid ? AN_OFF : ~(one << i);
            es = hid ? SB : sv[i];
            check(tag, {an, seg}, {ea, es});
            if (chg_at == i * 4 + c) set_d(chg_val);
         end
      end
   endtask

   initial begin
      set_d(20'h12345);
      #2 rst = 1'b1;
      #1 check("reset", {an, seg}, {AN_OFF, SB});
      @(negedge clk) rst = 1'b0;

      run_frame("first_blank", SB, SB, SB, SB, SB, 1'b0, -1, 20'h0);
      run_frame("show_12345", S5, S4, S3, S2, S1, 1'b0, -1, 20'h0);
      run_frame("no_tear", S5, S4, S3, S2, S1, 1'b0, 9, 20'h67890);
      run_frame("show_67890", S0, S9, S8, S7, S6, 1'b0, 10, 20'h00042);
      blank_lz = 1'b1;
      run_frame("lz_00042", S2, S4, SB, SB, SB, 1'b0, 10, 20'h00000);
      run_frame("lz_00000", S0, SB, SB, SB, SB, 1'b0, 10, 20'h00042);
      blank_lz = 1'b0;
      run_frame("nolz_00042", S2, S4, S0, S0, S0, 1'b0, 10, 20'hFFFFF);
      run_frame("all_15", SB, SB, SB, SB, SB, 1'b0, 10, 20'hFFCFF);
      run_frame("dash", SB, SB, SD, SB, SB, 1'b0, 10, 20'hFF007);
      blank_lz = 1'b1;
      run_frame("lz_over_15", S7, SB, SB, SB, SB, 1'b0, 10, 20'h12345);
      blank_lz = 1'b0;
      blink_en = 1'b1;
      run_frame("blink_f0", S5, S4, S3, S2, S1, 1'b0, -1, 20'h0);
      run_frame("blink_f1", S5, S4, S3, S2, S1, 1'b0, -1, 20'h0);
      run_frame("blink_f2", S5, S4, S3, S2, S1, 1'b1, -1, 20'h0);
      run_frame("blink_f3", S5, S4, S3, S2, S1, 1'b1, -1, 20'h0);
      run_frame("blink_f4", S5, S4, S3, S2, S1, 1'b0, -1, 20'h0);
      run_frame("blink_f5", S5, S4, S3, S2, S1, 1'b0, -1, 20'h0);
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check("blink_hid", {an, seg}, {AN_OFF, SB});
      end
      blink_en = 1'b0;
      tick(1);
      check("blink_drop", {an, seg}, {5'b11101, S4});
      tick(14);
      blink_en = 1'b1;
      run_frame("reblink_v0", S5, S4, S3, S2, S1, 1'b0, -1, 20'h0);
      run_frame("reblink_v1", S5, S4, S3, S2, S1, 1'b0, -1, 20'h0);
      run_frame("reblink_h", S5, S4, S3, S2, S1, 1'b1, -1, 20'h0);
      blink_en = 1'b0;
      tick(14);
      check("pre_rst", {an, seg}, {5'b10111, S2});
      rst = 1'b1;
      #1 check("async_rst", {an, seg}, {AN_OFF, SB});
      @(negedge clk) rst = 1'b0;
      run_frame("rst_blank", SB, SB, SB, SB, SB, 1'b0, -1, 20'h0);
      run_frame("rst_resume", S5, S4, S3, S2, S1, 1'b0, -1, 20'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
